// File: rtl/nibbler_bus_pkg.sv
// -----------------------------------------------------------------------------
// nibbler_bus_pkg
// Shared definitions for the nibble-bus arbiter slice.
//   state_e           : arbiter FSM state encoding (IDLE, DRIVE, TURN)
//   BUS_WIDTH_DEFAULT : default width of the shared bus in bits
// -----------------------------------------------------------------------------
package nibbler_bus_pkg;

  localparam int BUS_WIDTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    TURN  = 2'd2
  } state_e;

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker. Searches req starting one past the last
// owner and wrapping modulo N. The last owner itself is the final candidate,
// so a lone requester is always re-granted.
// Ports:
//   req    in  N   request vector
//   last   in  IW  index of the most recent owner
//   winner out IW  index of the selected requester (0 when none found)
//   found  out 1   at least one request bit was set
// -----------------------------------------------------------------------------
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [IW-1:0] winner,
  output logic          found
);

  // One extra bit holds last+k before the modulo fold.
  logic [IW:0]   cand;
  logic [IW-1:0] idx;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    cand   = '0;
    idx    = '0;
    for (int k = 1; k <= N; k++) begin
      cand = {1'b0, last} + (IW+1)'(k);
      if (cand >= (IW+1)'(N)) begin
        cand = cand - (IW+1)'(N);
      end
      idx = cand[IW-1:0];
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
// Round-robin owner selection for the shared nibble bus. Drives a one-hot
// driver enable, inserts a dead turnaround cycle after every transfer so two
// drivers never overlap, and registers the resolved bus value.
//
// Optional build macro: BUS_LOCK_EN
//   When defined, adds the `lock` input. An owner holding lock stays in DRIVE
//   for up to MAX_LOCK consecutive capture cycles before turning the bus round.
//
// Ports:
//   clock     in   1          rising-edge clock
//   reset     in   1          synchronous, active-high reset
//   lock      in   1          hold the bus (BUS_LOCK_EN builds only)
//   req       in   N          per-source request, sampled in IDLE/TURN only
//   bus_in    in   WIDTH      resolved shared bus value
//   enable    out  N          one-hot (or zero) bus-driver enable
//   ack       out  N          one-hot capture strobe for the current owner
//   owner     out  clog2(N)   current or most recent owner
//   bus_q     out  WIDTH      last captured bus value
//   bus_valid out  1          pulse the cycle after each capture
//   busy      out  1          high while in DRIVE or TURN
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | bus released, no driver enabled, arbitrating every cycle
// DRIVE | enable[owner] high, bus_in captured at the end of the cycle
// TURN  | dead cycle with all drivers off, arbitrating for the next owner
// -----------------------------------------------------------------------------
import nibbler_bus_pkg::*;

module bus_arbiter #(
  parameter int N        = 4,
  parameter int WIDTH    = BUS_WIDTH_DEFAULT,
  parameter int MAX_LOCK = 4
) (
  input  logic                 clock,
  input  logic                 reset,
`ifdef BUS_LOCK_EN
  input  logic                 lock,
`endif
  input  logic [N-1:0]         req,
  input  logic [WIDTH-1:0]     bus_in,
  output logic [N-1:0]         enable,
  output logic [N-1:0]         ack,
  output logic [$clog2(N)-1:0] owner,
  output logic [WIDTH-1:0]     bus_q,
  output logic                 bus_valid,
  output logic                 busy
);

  localparam int IW = $clog2(N);

  localparam logic [1:0] ST_IDLE  = 2'(IDLE);
  localparam logic [1:0] ST_DRIVE = 2'(DRIVE);
  localparam logic [1:0] ST_TURN  = 2'(TURN);

  if (N < 2 || N > 8 || MAX_LOCK < 1 || MAX_LOCK > 8) begin : g_param_check
    $error("bus_arbiter: N must be 2..8 and MAX_LOCK 1..8");
  end

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [IW-1:0] last;
  logic [IW-1:0] winner;
  logic          found;
  logic [N-1:0]  grant_oh;
  logic          hold;
  logic          entering_drive;

  rr_pick #(
    .N  (N),
    .IW (IW)
  ) u_pick (
    .req    (req),
    .last   (last),
    .winner (winner),
    .found  (found)
  );

  always_comb begin
    grant_oh         = '0;
    grant_oh[winner] = 1'b1;
  end

`ifdef BUS_LOCK_EN
  // Down-counter loaded on entry to DRIVE; zero marks the final allowed cycle.
  localparam logic [2:0] LOCK_LOAD = 3'(MAX_LOCK - 1);

  logic [2:0] lock_cnt;

  assign hold = lock && (lock_cnt != 3'd0);

  always_ff @(posedge clock) begin
    if (reset) begin
      lock_cnt <= 3'd0;
    end else if (entering_drive) begin
      lock_cnt <= LOCK_LOAD;
    end else if (state == ST_DRIVE && lock_cnt != 3'd0) begin
      lock_cnt <= lock_cnt - 3'd1;
    end
  end
`else
  assign hold = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  state_nxt = found ? ST_DRIVE : ST_IDLE;
      ST_DRIVE: state_nxt = hold  ? ST_DRIVE : ST_TURN;
      ST_TURN:  state_nxt = found ? ST_DRIVE : ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  assign entering_drive = (state_nxt == ST_DRIVE) && (state != ST_DRIVE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      enable    <= '0;
      owner     <= IW'(N - 1);
      last      <= IW'(N - 1);
      bus_q     <= '0;
      bus_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      busy      <= (state_nxt != ST_IDLE);
      bus_valid <= (state == ST_DRIVE);

      if (state == ST_DRIVE) begin
        bus_q <= bus_in;
        last  <= owner;
      end

      // Enable is held through a locked DRIVE and cleared in every other
      // transition out of DRIVE, which guarantees the dead TURN cycle.
      if (entering_drive) begin
        owner  <= winner;
        enable <= grant_oh;
      end else if (state_nxt != ST_DRIVE) begin
        enable <= '0;
      end
    end
  end

  always_comb begin
    ack = '0;
    if (state == ST_DRIVE) begin
      ack[owner] = 1'b1;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
module tb_bus_arbiter;

  logic       clock;
  logic       reset;
  logic [3:0] req;
  logic [3:0] bus_in;
  logic [3:0] enable;
  logic [3:0] ack;
  logic [1:0] owner;
  logic [3:0] bus_q;
  logic       bus_valid;
  logic       busy;
`ifdef BUS_LOCK_EN
  logic       lock;
`endif

  int checks;
  int failures;

  logic [3:0] src_data [4];

  bus_arbiter #(
    .N        (4),
    .WIDTH    (4),
    .MAX_LOCK (4)
  ) dut (
    .clock     (clock),
    .reset     (reset),
`ifdef BUS_LOCK_EN
    .lock      (lock),
`endif
    .req       (req),
    .bus_in    (bus_in),
    .enable    (enable),
    .ack       (ack),
    .owner     (owner),
    .bus_q     (bus_q),
    .bus_valid (bus_valid),
    .busy      (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Wired-OR bus: each enabled source contributes its data, idle bus reads 0.
  always_comb begin
    bus_in = 4'h0;
    for (int i = 0; i < 4; i++) begin
      if (enable[i]) bus_in = bus_in | src_data[i];
    end
  end

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    req   = 4'b0000;
    step();
    step();
    checks++; if (enable !== 4'b0000) begin failures++; $display("FAIL rst_enable got=%b exp=0000", enable); end
    checks++; if (owner !== 2'd3) begin failures++; $display("FAIL rst_owner got=%0d exp=3", owner); end
    checks++; if (bus_q !== 4'h0) begin failures++; $display("FAIL rst_bus_q got=%h exp=0", bus_q); end
    checks++; if (bus_valid !== 1'b0) begin failures++; $display("FAIL rst_bus_valid got=%b exp=0", bus_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
    checks++; if (ack !== 4'b0000) begin failures++; $display("FAIL rst_ack got=%b exp=0000", ack); end
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      checks++; if (enable !== 4'b0000) begin failures++; $display("FAIL idle_enable c=%0d got=%b exp=0000", c, enable); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_busy c=%0d got=%b exp=0", c, busy); end
      checks++; if (bus_valid !== 1'b0) begin failures++; $display("FAIL idle_valid c=%0d got=%b exp=0", c, bus_valid); end
      checks++; if (owner !== 2'd3) begin failures++; $display("FAIL idle_owner c=%0d got=%0d exp=3", c, owner); end
    end
  endtask

  task automatic test_single;
    req = 4'b0100;
    step();
    checks++; if (enable !== 4'b0100) begin failures++; $display("FAIL single_enable got=%b exp=0100", enable); end
    checks++; if (ack !== 4'b0100) begin failures++; $display("FAIL single_ack got=%b exp=0100", ack); end
    checks++; if (owner !== 2'd2) begin failures++; $display("FAIL single_owner got=%0d exp=2", owner); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy got=%b exp=1", busy); end
    checks++; if (bus_valid !== 1'b0) begin failures++; $display("FAIL single_valid_early got=%b exp=0", bus_valid); end
    req = 4'b0000;
    step();
    checks++; if (bus_q !== 4'b0101) begin failures++; $display("FAIL single_bus_q got=%b exp=0101", bus_q); end
    checks++; if (bus_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%b exp=1", bus_valid); end
    checks++; if (enable !== 4'b0000) begin failures++; $display("FAIL single_turn_enable got=%b exp=0000", enable); end
    checks++; if (ack !== 4'b0000) begin failures++; $display("FAIL single_turn_ack got=%b exp=0000", ack); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_turn_busy got=%b exp=1", busy); end
    step();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_idle_busy got=%b exp=0", busy); end
    checks++; if (bus_valid !== 1'b0) begin failures++; $display("FAIL single_idle_valid got=%b exp=0", bus_valid); end
  endtask

  task automatic test_round_robin;
    logic [3:0] exp_oh;
    int         exp_idx;
    reset = 1'b1;
    step();
    reset = 1'b0;
    req   = 4'b1111;
    for (int cyc = 0; cyc < 16; cyc++) begin
      step();
      exp_idx = (cyc / 2) % 4;
      exp_oh  = 4'b0001 << exp_idx;
      checks++; if ($countones(enable) > 1) begin failures++; $display("FAIL rr_onehot cyc=%0d got=%b exp=popcount<=1", cyc, enable); end
      if (cyc % 2 == 0) begin
        checks++; if (enable !== exp_oh) begin failures++; $display("FAIL rr_enable cyc=%0d got=%b exp=%b", cyc, enable, exp_oh); end
        checks++; if (ack !== exp_oh) begin failures++; $display("FAIL rr_ack cyc=%0d got=%b exp=%b", cyc, ack, exp_oh); end
        checks++; if (owner !== 2'(exp_idx)) begin failures++; $display("FAIL rr_owner cyc=%0d got=%0d exp=%0d", cyc, owner, exp_idx); end
      end else begin
        checks++; if (enable !== 4'b0000) begin failures++; $display("FAIL rr_turn cyc=%0d got=%b exp=0000", cyc, enable); end
        checks++; if (bus_q !== src_data[exp_idx]) begin failures++; $display("FAIL rr_bus_q cyc=%0d got=%h exp=%h", cyc, bus_q, src_data[exp_idx]); end
        checks++; if (bus_valid !== 1'b1) begin failures++; $display("FAIL rr_valid cyc=%0d got=%b exp=1", cyc, bus_valid); end
      end
    end
    req = 4'b0000;
    step();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rr_idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_drop_req;
    req = 4'b0010;
    step();
    checks++; if (enable !== 4'b0010) begin failures++; $display("FAIL drop_enable got=%b exp=0010", enable); end
    checks++; if (ack !== 4'b0010) begin failures++; $display("FAIL drop_ack got=%b exp=0010", ack); end
    req = 4'b0000;
    step();
    checks++; if (bus_q !== 4'b1010) begin failures++; $display("FAIL drop_bus_q got=%b exp=1010", bus_q); end
    checks++; if (bus_valid !== 1'b1) begin failures++; $display("FAIL drop_valid got=%b exp=1", bus_valid); end
    checks++; if (enable !== 4'b0000) begin failures++; $display("FAIL drop_turn got=%b exp=0000", enable); end
    step();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL drop_idle_busy got=%b exp=0", busy); end
    checks++; if (enable !== 4'b0000) begin failures++; $display("FAIL drop_idle_enable got=%b exp=0000", enable); end
  endtask

  task automatic test_back_to_back;
    req = 4'b0010;
    step();
    checks++; if (enable !== 4'b0010) begin failures++; $display("FAIL b2b_first got=%b exp=0010", enable); end
    step();
    checks++; if (enable !== 4'b0000) begin failures++; $display("FAIL b2b_turn got=%b exp=0000", enable); end
    step();
    checks++; if (enable !== 4'b0010) begin failures++; $display("FAIL b2b_regrant got=%b exp=0010", enable); end
    checks++; if (owner !== 2'd1) begin failures++; $display("FAIL b2b_owner got=%0d exp=1", owner); end
    req = 4'b0000;
    step();
    step();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_reset_in_drive;
    req = 4'b1000;
    step();
    checks++; if (enable !== 4'b1000) begin failures++; $display("FAIL rstdrv_enable got=%b exp=1000", enable); end
    checks++; if (owner !== 2'd3) begin failures++; $display("FAIL rstdrv_owner got=%0d exp=3", owner); end
    reset = 1'b1;
    req   = 4'b0000;
    step();
    checks++; if (enable !== 4'b0000) begin failures++; $display("FAIL rstdrv_enable_after got=%b exp=0000", enable); end
    checks++; if (bus_q !== 4'b0000) begin failures++; $display("FAIL rstdrv_bus_q got=%b exp=0000", bus_q); end
    checks++; if (bus_valid !== 1'b0) begin failures++; $display("FAIL rstdrv_valid got=%b exp=0", bus_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstdrv_busy got=%b exp=0", busy); end
    reset = 1'b0;
    req   = 4'b1111;
    step();
    checks++; if (enable !== 4'b0001) begin failures++; $display("FAIL rstdrv_first_grant got=%b exp=0001", enable); end
    checks++; if (owner !== 2'd0) begin failures++; $display("FAIL rstdrv_first_owner got=%0d exp=0", owner); end
    req = 4'b0000;
    step();
    step();
  endtask

`ifdef BUS_LOCK_EN
  task automatic test_lock;
    int pulses;
    pulses = 0;
    lock   = 1'b1;
    req    = 4'b0001;
    for (int i = 1; i <= 6; i++) begin
      step();
      if (i == 1) req = 4'b0000;
      if (bus_valid === 1'b1) pulses++;
      if (i <= 4) begin
        checks++; if (enable !== 4'b0001) begin failures++; $display("FAIL lock_enable i=%0d got=%b exp=0001", i, enable); end
        checks++; if (ack !== 4'b0001) begin failures++; $display("FAIL lock_ack i=%0d got=%b exp=0001", i, ack); end
      end else begin
        checks++; if (enable !== 4'b0000) begin failures++; $display("FAIL lock_release i=%0d got=%b exp=0000", i, enable); end
        checks++; if (ack !== 4'b0000) begin failures++; $display("FAIL lock_release_ack i=%0d got=%b exp=0000", i, ack); end
      end
    end
    checks++; if (pulses != 4) begin failures++; $display("FAIL lock_pulses got=%0d exp=4", pulses); end
    lock = 1'b0;
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog timeout got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    checks      = 0;
    failures    = 0;
    reset       = 1'b1;
    req         = 4'b0000;
`ifdef BUS_LOCK_EN
    lock        = 1'b0;
`endif
    src_data[0] = 4'h3;
    src_data[1] = 4'b1010;
    src_data[2] = 4'b0101;
    src_data[3] = 4'b1100;

    test_reset();
    test_single();
    test_round_robin();
    test_drop_req();
    test_back_to_back();
    test_reset_in_drive();
`ifdef BUS_LOCK_EN
    test_lock();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
